// File: rtl/sdram_arbiter_if.sv
// SDRAM arbiter bundle: sub-module enables/done/buses and muxed command bus.
// master = arbiter side, slave = sub-modules / pin stage side.
interface sdram_arbiter_if #(
  parameter int CMD_W  = 4,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int BUS_W  = CMD_W + 1 + ADDR_W + BA_W
);

  logic             init_done;
  logic [BUS_W-1:0] init_bus;
  logic             ref_en;
  logic             ref_done;
  logic [BUS_W-1:0] ref_bus;
  logic             wr_req;
  logic             wr_en;
  logic             wr_done;
  logic [BUS_W-1:0] wr_bus;
  logic             rd_req;
  logic             rd_en;
  logic             rd_done;
  logic [BUS_W-1:0] rd_bus;
  logic [BUS_W-1:0] sdram_bus;
  logic             ref_pending;

  modport master (
    input  init_done, init_bus,
    input  ref_done, ref_bus,
    input  wr_req, wr_done, wr_bus,
    input  rd_req, rd_done, rd_bus,
    output ref_en, wr_en, rd_en,
    output sdram_bus, ref_pending
  );

  modport slave (
    output init_done, init_bus,
    output ref_done, ref_bus,
    output wr_req, wr_done, wr_bus,
    output rd_req, rd_done, rd_bus,
    input  ref_en, wr_en, rd_en,
    input  sdram_bus, ref_pending
  );

endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: refresh timer plus init/ref/write/read bus grant.
// Optional RR_ARB_EN: alternate write/read priority on ties.
module sdram_arbiter #(
  parameter int              CMD_W      = 4,
  parameter int              ADDR_W     = 13,
  parameter int              BA_W       = 2,
  parameter int              BUS_W      = CMD_W + 1 + ADDR_W + BA_W,
  parameter logic [CMD_W-1:0] NOP_CMD   = 4'b0111,
  parameter int              REF_PERIOD = 780
) (
  input  logic             clk,
  input  logic             rst_n,
  sdram_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(REF_PERIOD + 1);

  typedef enum logic [4:0] {
    INIT  = 5'b00001,
    IDLE  = 5'b00010,
    REF   = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_pend;
  logic             ref_wrap;
  logic             ref_clr;
  logic             pick_wr;
  logic [BUS_W-1:0] bus_mux;

  assign ref_wrap = (ref_cnt == CNT_W'(REF_PERIOD - 1));
  assign ref_clr  = (state == REF) && bus.ref_done;

`ifdef RR_ARB_EN
  logic last_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (state == IDLE) begin
      if (state_nxt == WRITE) last_wr <= 1'b1;
      else if (state_nxt == READ) last_wr <= 1'b0;
    end
  end

  assign pick_wr = bus.wr_req && !(bus.rd_req && last_wr);
`else
  assign pick_wr = bus.wr_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Timer is frozen in INIT; a wrap beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else if (state != INIT) begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap) ref_pend <= 1'b1;
      else if (ref_clr) ref_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:  if (bus.init_done) state_nxt = IDLE;
      IDLE: begin
        if (ref_pend) state_nxt = REF;
        else if (pick_wr) state_nxt = WRITE;
        else if (bus.rd_req) state_nxt = READ;
      end
      REF:   if (bus.ref_done) state_nxt = IDLE;
      WRITE: if (bus.wr_done) state_nxt = IDLE;
      READ:  if (bus.rd_done) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    bus_mux = {NOP_CMD, 1'b1, {ADDR_W{1'b0}}, {BA_W{1'b0}}};
    unique case (1'b1)
      state[0]: bus_mux = bus.init_bus;
      state[2]: bus_mux = bus.ref_bus;
      state[3]: bus_mux = bus.wr_bus;
      state[4]: bus_mux = bus.rd_bus;
      default:  bus_mux = {NOP_CMD, 1'b1, {ADDR_W{1'b0}}, {BA_W{1'b0}}};
    endcase
  end

  assign bus.sdram_bus   = bus_mux;
  assign bus.ref_pending = ref_pend;
  assign bus.ref_en      = (state == REF);
  assign bus.wr_en       = (state == WRITE);
  assign bus.rd_en       = (state == READ);

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Top-level command arbiter of the SDRAM controller.
- Owns the periodic auto-refresh timer and grants the single SDRAM command bus to one sub-module at a time: init, refresh, write or read.
- Drives each sub-module's enable and consumes that module's done pulse and packed bus {cmd, cke, a, ba}.
- Its output bus feeds the SDRAM pin stage.

Parameters:
CMD_W, 4, command field width {cs_n, ras_n, cas_n, we_n}
ADDR_W, 13, address field width
BA_W, 2, bank address width
BUS_W, CMD_W+1+ADDR_W+BA_W (20), packed bus width
NOP_CMD, 4'b0111, command driven when no module is granted
REF_PERIOD, 780, cycles between refresh requests (7.8 us at 100 MHz)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
init_done  in  1  level; init sequence complete
init_bus  in  BUS_W  bus from init module
ref_en  out  1  grant/enable to refresh module
ref_done  in  1  one-cycle pulse, refresh complete
ref_bus  in  BUS_W  bus from refresh module
wr_req  in  1  level write request
wr_en  out  1  grant to write module
wr_done  in  1  one-cycle pulse
wr_bus  in  BUS_W  bus from write module
rd_req  in  1  level read request
rd_en  out  1  grant to read module
rd_done  in  1  one-cycle pulse
rd_bus  in  BUS_W  bus from read module
sdram_bus  out  BUS_W  muxed command bus {cmd, cke, a, ba}
ref_pending  out  1  refresh request outstanding

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset: state=INIT, ref_en=wr_en=rd_en=0, ref_pending=0, refresh counter=0.
- States (one-hot): INIT, IDLE, REF, WRITE, READ.
- Enables are registered: ref_en=1 exactly while in REF; wr_en in WRITE; rd_en in READ.
- sdram_bus is a combinational mux on state:
  - INIT: init_bus
  - REF: ref_bus
  - WRITE: wr_bus
  - READ: rd_bus
  - IDLE: {NOP_CMD, 1'b1, 0, 0}
- INIT -> IDLE on the edge where init_done=1.
- Refresh timer:
  - Counts only after leaving INIT; counts 0..REF_PERIOD-1, then wraps.
  - At count==REF_PERIOD-1, sets ref_pending.
  - ref_pending clears on a ref_done sampled in REF.
  - If set and clear occur in the same cycle, set wins.
- IDLE arbitration, sampled each cycle, fixed priority: ref_pending > wr_req > rd_req. Grant takes effect next cycle (1-cycle latency from request to enable).
- REF/WRITE/READ: hold until the matching done is sampled, then IDLE next cycle. Other inputs are ignored during a grant.
- Minimum one IDLE cycle between grants, so every enable drops for at least one cycle and the sub-module's state machine is reset by its enable going low.
- Requesters deassert req the cycle after their done; a req still high in IDLE is re-granted normally.
- A done pulse from a non-granted module is ignored.
- A refresh period expiring during WRITE/READ only sets ref_pending; it is served at the next IDLE.
- Reset mid-grant: immediate return to INIT with all enables 0; refresh timer restarts after init_done.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: write/read priority alternates. A 1-bit last_grant flag records the last of WRITE/READ granted; when both wr_req and rd_req are high in IDLE, the one not last granted wins. last_grant resets to READ, so write wins the first tie. Refresh still has top priority.
- Undefined: fixed wr > rd priority, no last_grant flag.

Test Plan:
- Bench uses REF_PERIOD=20.
- Reset, then init_done high at cycle 5 -> sdram_bus follows init_bus until state IDLE; in IDLE, sdram_bus = {4'b0111, 1, 0, 0}; all enables 0.
- Refresh timing: 20 cycles after leaving INIT -> ref_pending=1, ref_en=1 one cycle later. Pulse ref_done -> ref_en=0 next cycle, ref_pending=0.
- wr_req and rd_req both held high -> wr_en first. After wr_done, one IDLE cycle, then rd_en if wr_req dropped. With RR_ARB_EN and both kept high -> grants alternate wr, rd, wr.
- Refresh expiry during a 30-cycle write -> wr_en stays 1 until wr_done, ref_pending=1 meanwhile. Then ref_en granted ahead of a pending rd_req.
- Stray rd_done pulse during REF -> ignored, state stays REF. rst_n=0 during WRITE -> next cycle state INIT, wr_en=0, ref_pending=0.
